// File: rtl/mul4_eval_pkg.sv
// Shared types, constants and the golden 32x32 multiply used to grade
// a candidate mul4 individual.
package mul4_eval_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } eval_state_t;

   localparam logic [63:0] LFSR_MASK   = 64'hD800_0000_0000_0000;
   localparam logic [15:0] NO_MISMATCH = 16'hFFFF;

   function automatic logic [63:0] golden_mul4(input logic [15:0] a1,
                                               input logic [15:0] a0,
                                               input logic [15:0] b1,
                                               input logic [15:0] b0);
      logic [63:0] op_a;
      logic [63:0] op_b;
      op_a = {32'd0, a1, a0};
      op_b = {32'd0, b1, b0};
      return op_a * op_b;
   endfunction

endpackage

// File: rtl/mul4_lfsr64.sv
// 64-bit Galois right-shift LFSR supplying operand sets; a zero seed is
// replaced by 1 so the register can never lock up in the all-zero state.
module mul4_lfsr64
   import mul4_eval_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        enable,
   input  logic [63:0] seed,
   output logic [63:0] state
);

   logic [63:0] lfsr_d;
   logic [63:0] lfsr_q;

   // Next LFSR value: load has priority over stepping.
   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = (seed == 64'd0) ? 64'd1 : seed;
      end else if (enable) begin
         lfsr_d = {1'b0, lfsr_q[63:1]} ^ (lfsr_q[0] ? LFSR_MASK : 64'd0);
      end else begin
         lfsr_d = lfsr_q;
      end
   end

   // LFSR register.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 64'd1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state = lfsr_q;

endmodule

// File: rtl/mul4_fitness_sequencer.sv
// Drives pseudo-random operands into a combinational mul4 candidate, grades
// every 16-bit result word against the golden product and reports the score.
module mul4_fitness_sequencer
   import mul4_eval_pkg::*;
#(
   parameter int NUM_VECTORS = 64,
   parameter int SCORE_W     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [63:0]        seed,
   output logic [15:0]        a1,
   output logic [15:0]        a0,
   output logic [15:0]        b1,
   output logic [15:0]        b0,
   input  logic [15:0]        y3,
   input  logic [15:0]        y2,
   input  logic [15:0]        y1,
   input  logic [15:0]        y0,
   output logic               busy,
   output logic               done,
   output logic               aborted,
   output logic [SCORE_W-1:0] score,
   output logic               perfect,
   output logic [15:0]        first_mismatch
);

   if (NUM_VECTORS < 1 || NUM_VECTORS > 65535) begin : g_bad_num_vectors
      $error("NUM_VECTORS must lie in 1..65535");
   end
   if ((longint'(1) << SCORE_W) <= longint'(4) * longint'(NUM_VECTORS)) begin : g_bad_score_w
      $error("SCORE_W too narrow: 2**SCORE_W must exceed 4*NUM_VECTORS");
   end

   localparam logic [15:0]        LAST_IDX   = 16'(NUM_VECTORS - 1);
   localparam logic [SCORE_W-1:0] FULL_SCORE = SCORE_W'(4 * NUM_VECTORS);

   eval_state_t        state_d, state_q;
   logic [15:0]        idx_d, idx_q;
   logic [SCORE_W-1:0] score_d, score_q;
   logic [15:0]        fm_d, fm_q;
   logic               aborted_d, aborted_q;
   logic               perfect_d, perfect_q;
   logic               busy_d, busy_q;
   logic               done_d, done_q;

   logic               lfsr_load;
   logic               lfsr_en;
   logic [63:0]        lfsr_state;
   logic [63:0]        golden;
   logic [2:0]         match_cnt;
   logic [SCORE_W-1:0] score_sum;

   mul4_lfsr64 u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .load   (lfsr_load),
      .enable (lfsr_en),
      .seed   (seed),
      .state  (lfsr_state)
   );

   assign golden    = golden_mul4(lfsr_state[63:48], lfsr_state[47:32],
                                  lfsr_state[31:16], lfsr_state[15:0]);
   assign match_cnt = 3'(y0 == golden[15:0])  + 3'(y1 == golden[31:16]) +
                      3'(y2 == golden[47:32]) + 3'(y3 == golden[63:48]);
   assign score_sum = score_q + SCORE_W'(match_cnt);

   // Sequencer next state; abort outranks both scoring and start in RUN.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      score_d   = score_q;
      fm_d      = fm_q;
      aborted_d = aborted_q;
      perfect_d = perfect_q;
      busy_d    = busy_q;
      done_d    = done_q;
      lfsr_load = 1'b0;
      lfsr_en   = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               lfsr_load = 1'b1;
               idx_d     = 16'd0;
               score_d   = '0;
               fm_d      = NO_MISMATCH;
               aborted_d = 1'b0;
               perfect_d = 1'b0;
               busy_d    = 1'b1;
               done_d    = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         RUN: begin
            lfsr_en = 1'b1;
            if (abort) begin
               state_d   = DONE;
               aborted_d = 1'b1;
               perfect_d = 1'b0;
               busy_d    = 1'b0;
               done_d    = 1'b1;
            end else begin
               score_d = score_sum;
               idx_d   = idx_q + 16'd1;
               if (match_cnt != 3'd4 && fm_q == NO_MISMATCH) begin
                  fm_d = idx_q;
               end else begin
                  fm_d = fm_q;
               end
               if (idx_q == LAST_IDX) begin
                  state_d   = DONE;
                  perfect_d = (score_sum == FULL_SCORE);
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= 16'd0;
         score_q   <= '0;
         fm_q      <= NO_MISMATCH;
         aborted_q <= 1'b0;
         perfect_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         score_q   <= score_d;
         fm_q      <= fm_d;
         aborted_q <= aborted_d;
         perfect_q <= perfect_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign a1             = lfsr_state[63:48];
   assign a0             = lfsr_state[47:32];
   assign b1             = lfsr_state[31:16];
   assign b0             = lfsr_state[15:0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign aborted        = aborted_q;
   assign score          = score_q;
   assign perfect        = perfect_q;
   assign first_mismatch = fm_q;

endmodule

// File: tb/tb_mul4_fitness_sequencer.sv
// Scoreboard bench: two sequencers (4 and 64 vectors) each grading a
// behavioural multiplier that can optionally corrupt its top result word.
module tb_mul4_fitness_sequencer;

   localparam int N0 = 4;
   localparam int N1 = 64;
   localparam int SW = 18;

   typedef struct packed {
      logic [SW-1:0] score;
      logic          perfect;
      logic [15:0]   fm;
      logic          aborted;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          start_v   [2];
   logic          abort_v   [2];
   logic [63:0]   seed_v    [2];
   logic          inv3_v    [2];
   logic [15:0]   a1_v [2], a0_v [2], b1_v [2], b0_v [2];
   logic [15:0]   y3_v [2], y2_v [2], y1_v [2], y0_v [2];
   logic          busy_v    [2];
   logic          done_v    [2];
   logic          aborted_v [2];
   logic          perfect_v [2];
   logic [SW-1:0] score_v   [2];
   logic [15:0]   fm_v      [2];

   int checks   = 0;
   int failures = 0;

   logic [63:0] op_q  [$];
   res_t        res_q [$];

   for (genvar g = 0; g < 2; g++) begin : g_cand
      logic [63:0] prod;
      assign prod    = {32'd0, a1_v[g], a0_v[g]} * {32'd0, b1_v[g], b0_v[g]};
      assign y3_v[g] = inv3_v[g] ? ~prod[63:48] : prod[63:48];
      assign y2_v[g] = prod[47:32];
      assign y1_v[g] = prod[31:16];
      assign y0_v[g] = prod[15:0];
   end

   mul4_fitness_sequencer #(.NUM_VECTORS(N0), .SCORE_W(SW)) u_dut4 (
      .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .seed(seed_v[0]),
      .a1(a1_v[0]), .a0(a0_v[0]), .b1(b1_v[0]), .b0(b0_v[0]),
      .y3(y3_v[0]), .y2(y2_v[0]), .y1(y1_v[0]), .y0(y0_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .aborted(aborted_v[0]), .score(score_v[0]),
      .perfect(perfect_v[0]), .first_mismatch(fm_v[0])
   );

   mul4_fitness_sequencer #(.NUM_VECTORS(N1), .SCORE_W(SW)) u_dut64 (
      .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .seed(seed_v[1]),
      .a1(a1_v[1]), .a0(a0_v[1]), .b1(b1_v[1]), .b0(b0_v[1]),
      .y3(y3_v[1]), .y2(y2_v[1]), .y1(y1_v[1]), .y0(y0_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .aborted(aborted_v[1]), .score(score_v[1]),
      .perfect(perfect_v[1]), .first_mismatch(fm_v[1])
   );

   function automatic logic [63:0] m_next(input logic [63:0] s);
      return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'd0);
   endfunction

   // Reference model: queue every presented operand set and the final result.
   task automatic push_expect(input logic [63:0] seed, input bit inv3,
                              input int n, input int abort_at);
      logic [63:0] s, g, c;
      int          m;
      res_t        r;
      s         = (seed == 64'd0) ? 64'd1 : seed;
      r.score   = '0;
      r.fm      = 16'hFFFF;
      r.aborted = (abort_at >= 0);
      for (int k = 0; k < n; k++) begin
         op_q.push_back(s);
         if (k == abort_at) break;
         g = {32'd0, s[63:32]} * {32'd0, s[31:0]};
         c = inv3 ? (g ^ {16'hFFFF, 48'd0}) : g;
         m = 0;
         for (int w = 0; w < 4; w++) if (c[16*w +: 16] == g[16*w +: 16]) m++;
         r.score = r.score + SW'(m);
         if (m < 4 && r.fm == 16'hFFFF) r.fm = 16'(k);
         s = m_next(s);
      end
      r.perfect = (abort_at < 0) && (r.score == SW'(4 * n));
      res_q.push_back(r);
   endtask

   // Start a run and follow it to done, comparing operands every vector.
   task automatic drive_run(input int u, input logic [63:0] seed, input int abort_at,
                            input int restart_at, input logic [63:0] restart_seed,
                            output int cyc);
      logic [63:0] exp_ops, got_ops;
      start_v[u] = 1'b1;
      seed_v[u]  = seed;
      @(negedge clk);
      start_v[u] = 1'b0;
      cyc = 0;
      checks++;
      if (score_v[u] !== '0 || fm_v[u] !== 16'hFFFF || aborted_v[u] !== 1'b0) begin
         failures++;
         $display("FAIL start_clear u=%0d score=%0d fm=%h aborted=%b want 0/ffff/0",
                  u, score_v[u], fm_v[u], aborted_v[u]);
      end
      while (done_v[u] !== 1'b1 && cyc < 300) begin
         checks++;
         if (op_q.size() == 0) begin
            failures++;
            $display("FAIL operands u=%0d cyc=%0d got vector but none expected", u, cyc);
         end else begin
            exp_ops = op_q.pop_front();
            got_ops = {a1_v[u], a0_v[u], b1_v[u], b0_v[u]};
            if (got_ops !== exp_ops) begin
               failures++;
               $display("FAIL operands u=%0d cyc=%0d got=%h want=%h", u, cyc, got_ops, exp_ops);
            end
         end
         checks++;
         if (busy_v[u] !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_run u=%0d cyc=%0d got=%b want=1", u, cyc, busy_v[u]);
         end
         if (cyc == abort_at) abort_v[u] = 1'b1;
         if (cyc == restart_at) begin
            start_v[u] = 1'b1;
            seed_v[u]  = restart_seed;
         end
         @(negedge clk);
         abort_v[u] = 1'b0;
         start_v[u] = 1'b0;
         cyc++;
      end
      checks++;
      if (done_v[u] !== 1'b1 || busy_v[u] !== 1'b0) begin
         failures++;
         $display("FAIL done_reached u=%0d done=%b busy=%b want 1/0", u, done_v[u], busy_v[u]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         checks++;
         if ({busy_v[u], done_v[u], aborted_v[u], perfect_v[u], score_v[u], fm_v[u]}
             !== {4'b0000, 18'd0, 16'hFFFF}) begin
            failures++;
            $display("FAIL reset_status u=%0d busy=%b done=%b ab=%b perf=%b score=%0d fm=%h want 0/0/0/0/0/ffff",
                     u, busy_v[u], done_v[u], aborted_v[u], perfect_v[u], score_v[u], fm_v[u]);
         end
         checks++;
         if ({a1_v[u], a0_v[u], b1_v[u], b0_v[u]} !== 64'd1) begin
            failures++;
            $display("FAIL reset_operands u=%0d got=%h want=0000000000000001",
                     u, {a1_v[u], a0_v[u], b1_v[u], b0_v[u]});
         end
      end
   endtask

   task automatic test_perfect();
      int   cyc;
      res_t exp_r;
      inv3_v[0] = 1'b0;
      push_expect(64'h1234, 1'b0, N0, -1);
      drive_run(0, 64'h1234, -1, -1, 64'd0, cyc);
      exp_r = res_q.pop_front();
      checks++;
      if (cyc != N0) begin
         failures++;
         $display("FAIL perfect_latency got=%0d want=%0d", cyc, N0);
      end
      checks++;
      if ({score_v[0], perfect_v[0], fm_v[0], aborted_v[0]} !== exp_r || score_v[0] !== 18'd16) begin
         failures++;
         $display("FAIL perfect_result got score=%0d perf=%b fm=%h ab=%b want score=%0d perf=%b fm=%h ab=%b",
                  score_v[0], perfect_v[0], fm_v[0], aborted_v[0],
                  exp_r.score, exp_r.perfect, exp_r.fm, exp_r.aborted);
      end
   endtask

   task automatic test_y3_inverted();
      int   cyc;
      res_t exp_r;
      inv3_v[0] = 1'b1;
      push_expect(64'hCAFE_F00D_1357_9BDF, 1'b1, N0, -1);
      drive_run(0, 64'hCAFE_F00D_1357_9BDF, -1, -1, 64'd0, cyc);
      exp_r = res_q.pop_front();
      inv3_v[0] = 1'b0;
      checks++;
      if ({score_v[0], perfect_v[0], fm_v[0], aborted_v[0]} !== exp_r ||
          score_v[0] !== 18'd12 || fm_v[0] !== 16'd0 || perfect_v[0] !== 1'b0) begin
         failures++;
         $display("FAIL y3_inverted got score=%0d perf=%b fm=%h want score=12 perf=0 fm=0000",
                  score_v[0], perfect_v[0], fm_v[0]);
      end
   endtask

   task automatic test_seed_zero();
      int   cyc;
      res_t exp_r;
      for (int i = 0; i < 2; i++) begin
         push_expect(64'(i), 1'b0, N0, -1);
         drive_run(0, 64'(i), -1, -1, 64'd0, cyc);
         exp_r = res_q.pop_front();
         checks++;
         if ({score_v[0], perfect_v[0], fm_v[0], aborted_v[0]} !== exp_r || score_v[0] !== 18'd16) begin
            failures++;
            $display("FAIL seed_%0d_result got score=%0d perf=%b fm=%h want score=%0d perf=%b fm=%h",
                     i, score_v[0], perfect_v[0], fm_v[0], exp_r.score, exp_r.perfect, exp_r.fm);
         end
      end
   endtask

   task automatic test_abort();
      int   cyc;
      res_t exp_r;
      inv3_v[1] = 1'b0;
      push_expect(64'h0BAD_5EED_0000_7777, 1'b0, N1, 2);
      drive_run(1, 64'h0BAD_5EED_0000_7777, 2, -1, 64'd0, cyc);
      exp_r = res_q.pop_front();
      checks++;
      if (cyc != 3) begin
         failures++;
         $display("FAIL abort_latency got=%0d want=3", cyc);
      end
      checks++;
      if ({score_v[1], perfect_v[1], fm_v[1], aborted_v[1]} !== exp_r ||
          score_v[1] !== 18'd8 || aborted_v[1] !== 1'b1) begin
         failures++;
         $display("FAIL abort_result got score=%0d perf=%b fm=%h ab=%b want score=8 perf=0 fm=ffff ab=1",
                  score_v[1], perfect_v[1], fm_v[1], aborted_v[1]);
      end
      abort_v[1] = 1'b1;
      @(negedge clk);
      abort_v[1] = 1'b0;
      @(negedge clk);
      checks++;
      if (done_v[1] !== 1'b1 || score_v[1] !== 18'd8 || aborted_v[1] !== 1'b1) begin
         failures++;
         $display("FAIL abort_in_done got done=%b score=%0d ab=%b want 1/8/1",
                  done_v[1], score_v[1], aborted_v[1]);
      end
   endtask

   task automatic test_start_in_run();
      int   cyc;
      res_t exp_r;
      push_expect(64'h89AB_CDEF_0123_4567, 1'b0, N1, -1);
      drive_run(1, 64'h89AB_CDEF_0123_4567, -1, 10, 64'h5555_AAAA_5555_AAAA, cyc);
      exp_r = res_q.pop_front();
      checks++;
      if (cyc != N1) begin
         failures++;
         $display("FAIL start_in_run_latency got=%0d want=%0d", cyc, N1);
      end
      checks++;
      if ({score_v[1], perfect_v[1], fm_v[1], aborted_v[1]} !== exp_r || score_v[1] !== 18'd256) begin
         failures++;
         $display("FAIL start_in_run_result got score=%0d perf=%b fm=%h want score=256 perf=1 fm=ffff",
                  score_v[1], perfect_v[1], fm_v[1]);
      end
   endtask

   task automatic test_back_to_back();
      int   cyc;
      res_t exp_r;
      inv3_v[1] = 1'b1;
      push_expect(64'h0F0F_1E1E_2D2D_3C3C, 1'b1, N1, -1);
      drive_run(1, 64'h0F0F_1E1E_2D2D_3C3C, -1, -1, 64'd0, cyc);
      exp_r = res_q.pop_front();
      inv3_v[1] = 1'b0;
      checks++;
      if (cyc != N1 || {score_v[1], perfect_v[1], fm_v[1], aborted_v[1]} !== exp_r) begin
         failures++;
         $display("FAIL back_to_back got cyc=%0d score=%0d perf=%b fm=%h want cyc=%0d score=%0d perf=%b fm=%h",
                  cyc, score_v[1], perfect_v[1], fm_v[1], N1, exp_r.score, exp_r.perfect, exp_r.fm);
      end
   endtask

   task automatic test_rst_mid_run();
      start_v[1] = 1'b1;
      seed_v[1]  = 64'h1111_2222_3333_4444;
      @(negedge clk);
      start_v[1] = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (busy_v[1] !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre_busy got=%b want=1", busy_v[1]);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy_v[1], done_v[1], score_v[1], fm_v[1], a1_v[1], a0_v[1], b1_v[1], b0_v[1]}
          !== {2'b00, 18'd0, 16'hFFFF, 64'd1}) begin
         failures++;
         $display("FAIL rst_mid_run got busy=%b done=%b score=%0d fm=%h ops=%h want 0/0/0/ffff/0000000000000001",
                  busy_v[1], done_v[1], score_v[1], fm_v[1], {a1_v[1], a0_v[1], b1_v[1], b0_v[1]});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      for (int u = 0; u < 2; u++) begin
         start_v[u] = 1'b0;
         abort_v[u] = 1'b0;
         seed_v[u]  = 64'd0;
         inv3_v[u]  = 1'b0;
      end
      test_reset();
      test_perfect();
      test_y3_inverted();
      test_seed_zero();
      test_abort();
      test_start_in_run();
      test_back_to_back();
      test_rst_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
